// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_pkg
//  Purpose  : Shared TMDS definitions: the four 10-bit control tokens (also
//             used by the transmit encoder), the alignment FSM state type and
//             a small elaboration-time helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package tmds_pkg;

  // Control tokens as serialised by the encoder, bit 9 = MSB.
  localparam logic [9:0] c_token_00 = 10'b1101010100;
  localparam logic [9:0] c_token_01 = 10'b0010101011;
  localparam logic [9:0] c_token_10 = 10'b0101010100;
  localparam logic [9:0] c_token_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_decoder_if
//  Purpose  : Bundles the symbol input and decoded outputs of one TMDS
//             channel decoder.
//  Signals  : i_tmds[9:0] raw symbol, o_pixel[7:0], o_ctrl[1:0], o_de,
//             o_bitslip, o_locked
//  Modports : master - deserializer/consumer side (drives i_tmds)
//             slave  - decoder side (drives the outputs)
//  Revision : 1.0 - initial release
// ============================================================================
interface tmds_decoder_if;
  logic [9:0] i_tmds;
  logic [7:0] o_pixel;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_bitslip;
  logic       o_locked;

  modport master (
    output i_tmds,
    input  o_pixel, o_ctrl, o_de, o_bitslip, o_locked
  );

  modport slave (
    input  i_tmds,
    output o_pixel, o_ctrl, o_de, o_bitslip, o_locked
  );
endinterface
`default_nettype wire

// File: rtl/tmds_symbol_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_symbol_decode
//  Purpose  : Purely combinational decode of one 10-bit TMDS symbol into a
//             control-token flag, the token value and the 8-bit pixel value.
//  Ports    : i_word[9:0]  symbol (bit 9 = MSB)
//             o_is_ctrl    symbol is one of the four control tokens
//             o_ctrl[1:0]  token value (C1,C0), 0 when not a token
//             o_pixel[7:0] data decode (valid only when o_is_ctrl = 0)
//  Revision : 1.0 - initial release
// ============================================================================
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_word,
  output logic       o_is_ctrl,
  output logic [1:0] o_ctrl,
  output logic [7:0] o_pixel
);

  logic [7:0] w_v;

  always_comb begin
    o_is_ctrl = 1'b1;
    o_ctrl    = 2'b00;
    case (i_word)
      c_token_00: o_ctrl = 2'b00;
      c_token_01: o_ctrl = 2'b01;
      c_token_10: o_ctrl = 2'b10;
      c_token_11: o_ctrl = 2'b11;
      default:    o_is_ctrl = 1'b0;
    endcase
  end

  // Bit 9 flags DC-balance inversion; bit 8 selects XOR vs XNOR chaining.
  always_comb begin
    w_v        = i_word[9] ? ~i_word[7:0] : i_word[7:0];
    o_pixel    = 8'h00;
    o_pixel[0] = w_v[0];
    for (int n = 1; n < 8; n++) begin
      o_pixel[n] = i_word[8] ? (w_v[n] ^ w_v[n-1]) : ~(w_v[n] ^ w_v[n-1]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_decoder
//  Purpose  : Sink-side TMDS channel decoder. Registers the deserialized
//             symbol, searches for symbol alignment by requesting bitslips
//             until a run of control tokens is seen, then outputs decoded
//             pixel/control/data-enable with a 2-cycle latency.
//  Ports    : i_clk  pixel clock
//             i_rst  asynchronous active-high reset
//             bus    tmds_decoder_if.slave (i_tmds in; o_pixel, o_ctrl,
//                    o_de, o_bitslip, o_locked out)
//  Revision : 1.0 - initial release
// ============================================================================
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_WAIT     = 16,
  parameter int CTRL_REPEAT   = 8,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic           i_clk,
  input  logic           i_rst,
  tmds_decoder_if.slave  bus
);

  localparam int CNT_W  = $clog2(max_int(SEARCH_WINDOW, LOCK_TIMEOUT) + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int RUN_W  = $clog2(CTRL_REPEAT + 1);

  // Stage 1
  logic [9:0]       r_q;
  logic             w_is_ctrl;
  logic [1:0]       w_ctrl;
  logic [7:0]       w_pixel;

  // FSM
  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_idle, w_idle_next, w_idle_inc;
  logic [RUN_W-1:0] r_run, w_run_next, w_run_inc;
  logic [WAIT_W-1:0] r_wait, w_wait_next, w_wait_inc;
  logic             w_bitslip_next;
  logic             w_locked_next;

  // Stage 2
  logic [7:0]       r_pixel;
  logic [1:0]       r_ctrl;
  logic             r_de;
  logic             r_bitslip;

  tmds_symbol_decode u_symbol_decode (
    .i_word    (r_q),
    .o_is_ctrl (w_is_ctrl),
    .o_ctrl    (w_ctrl),
    .o_pixel   (w_pixel)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else begin
      r_q <= bus.i_tmds;
    end
  end

  // Saturating increments: counters never wrap.
  always_comb begin
    w_idle_inc = (r_idle == {CNT_W{1'b1}})  ? r_idle : r_idle + 1'b1;
    w_run_inc  = (r_run  == {RUN_W{1'b1}})  ? r_run  : r_run  + 1'b1;
    w_wait_inc = (r_wait == {WAIT_W{1'b1}}) ? r_wait : r_wait + 1'b1;
  end

  always_comb begin
    w_state_next   = r_state;
    w_idle_next    = r_idle;
    w_run_next     = r_run;
    w_wait_next    = r_wait;
    w_bitslip_next = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        // A token clears idle, so lock and slip cannot fire together;
        // checking the token branch first gives lock priority regardless.
        if (w_is_ctrl) begin
          w_idle_next = '0;
          w_run_next  = w_run_inc;
          if (w_run_inc == RUN_W'(CTRL_REPEAT)) begin
            w_state_next = ST_LOCKED;
            w_run_next   = '0;
          end
        end else begin
          w_run_next  = '0;
          w_idle_next = w_idle_inc;
          if (w_idle_inc == CNT_W'(SEARCH_WINDOW)) begin
            w_state_next   = ST_SLIP_WAIT;
            w_bitslip_next = 1'b1;
            w_idle_next    = '0;
            w_wait_next    = '0;
          end
        end
      end
      ST_SLIP_WAIT: begin
        w_wait_next = w_wait_inc;
        if (w_wait_inc == WAIT_W'(SLIP_WAIT)) begin
          w_state_next = ST_SEARCH;
          w_wait_next  = '0;
          w_idle_next  = '0;
          w_run_next   = '0;
        end
      end
      ST_LOCKED: begin
        if (w_is_ctrl) begin
          w_idle_next = '0;
        end else begin
          w_idle_next = w_idle_inc;
          if (w_idle_inc == CNT_W'(LOCK_TIMEOUT)) begin
            w_state_next = ST_SEARCH;
            w_idle_next  = '0;
            w_run_next   = '0;
          end
        end
      end
      default: begin
        w_state_next = ST_SEARCH;
        w_idle_next  = '0;
        w_run_next   = '0;
        w_wait_next  = '0;
      end
    endcase
  end

  // Output gating follows the state being entered, so o_de/o_pixel drop on
  // the same edge that drops o_locked and never show data while unlocked.
  assign w_locked_next = (w_state_next == ST_LOCKED);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_SEARCH;
      r_idle    <= '0;
      r_run     <= '0;
      r_wait    <= '0;
      r_bitslip <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idle    <= w_idle_next;
      r_run     <= w_run_next;
      r_wait    <= w_wait_next;
      r_bitslip <= w_bitslip_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pixel <= '0;
      r_ctrl  <= '0;
      r_de    <= 1'b0;
    end else if (w_is_ctrl) begin
      r_de   <= 1'b0;
      r_ctrl <= w_ctrl;
      if (!w_locked_next) begin
        r_pixel <= '0;
      end
    end else if (w_locked_next) begin
      r_de    <= 1'b1;
      r_pixel <= w_pixel;
    end else begin
      r_de    <= 1'b0;
      r_pixel <= '0;
    end
  end

  assign bus.o_pixel   = r_pixel;
  assign bus.o_ctrl    = r_ctrl;
  assign bus.o_de      = r_de;
  assign bus.o_bitslip = r_bitslip;
  assign bus.o_locked  = (r_state == ST_LOCKED);

endmodule
`default_nettype wire
